vpu_pathway_sequencer: RTL and testbench

- Command-driven controller that owns the VPU `data_pathway` select for the duration of one job.
- Accepts one job at a time: pathway code plus row count. Holds the pathway stable while the job runs.
- Counts systolic-array valids entering the VPU and VPU valids leaving it, per lane. Publishes per-lane row indices so the UB can present bias/Y/H operands.
- Reports completion, or an error (bad command, overflow, timeout). Sits between the top-level training control FSM and the vpu.

---
 rtl/vpu_pathway_sequencer.sv | 139 +++++++++++++
 tb/tb_vpu_pathway_sequencer.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/vpu_pathway_sequencer.sv
// vpu_pathway_sequencer: owns the VPU data_pathway select for one job,
// counting lane valids in/out and flagging completion, overflow, timeout.
module vpu_pathway_sequencer #(
    parameter int ROW_W       = 16,
    parameter int TIMEOUT_CYC = 64,
    parameter int TO_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_pathway,
    input  logic [ROW_W-1:0] cmd_num_rows,
    input  logic             abort,
    input  logic             vpu_valid_in_1,
    input  logic             vpu_valid_in_2,
    input  logic             vpu_valid_out_1,
    input  logic             vpu_valid_out_2,
    output logic [2:0]       data_pathway,
    output logic [ROW_W-1:0] row_idx_1,
    output logic [ROW_W-1:0] row_idx_2,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [1:0]       err_code
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t           state_q, state_d;
    logic [2:0]       pw_q, pw_d, dp_q;
    logic [ROW_W-1:0] n_q, n_d, in1_q, in1_d, in2_q, in2_d, out1_q, out1_d, out2_q, out2_d;
    logic [TO_W-1:0]  to_q, to_d;
    logic [1:0]       ec_q, ec_d;
    logic             err_q, err_d, busy_q, done_q;
    logic             active, cmd_ok, ovf;

    assign active = (state_q == RUN) || (state_q == DRAIN);
    assign cmd_ok = (cmd_pathway != 3'b000) && (cmd_pathway <= 3'b011) && (cmd_num_rows != '0);
    assign ovf    = (vpu_valid_in_1 && in1_q == n_q) || (vpu_valid_in_2 && in2_q == n_q) ||
                    (vpu_valid_out_1 && out1_q == n_q) || (vpu_valid_out_2 && out2_q == n_q);

    always_comb begin
        state_d = state_q;
        pw_d    = pw_q;
        n_d     = n_q;
        in1_d   = in1_q;
        in2_d   = in2_q;
        out1_d  = out1_q;
        out2_d  = out2_q;
        to_d    = to_q;
        err_d   = 1'b0;
        ec_d    = ec_q;
        if (active) begin
            in1_d  = in1_q + ROW_W'(vpu_valid_in_1 && in1_q != n_q);
            in2_d  = in2_q + ROW_W'(vpu_valid_in_2 && in2_q != n_q);
            out1_d = out1_q + ROW_W'(vpu_valid_out_1 && out1_q != n_q);
            out2_d = out2_q + ROW_W'(vpu_valid_out_2 && out2_q != n_q);
            err_d  = ovf;
            ec_d   = ovf ? 2'b10 : ec_q;
        end
        case (state_q)
            IDLE: if (cmd_valid) begin
                if (cmd_ok) begin
                    state_d = RUN;
                    pw_d    = cmd_pathway;
                    n_d     = cmd_num_rows;
                    in1_d   = '0;
                    in2_d   = '0;
                    out1_d  = '0;
                    out2_d  = '0;
                    to_d    = '0;
                    ec_d    = 2'b00;
                end else begin
                    err_d = 1'b1;
                    ec_d  = 2'b01;
                end
            end
            RUN: state_d = (in1_q == n_q && in2_q == n_q) ? DRAIN : RUN;
            DRAIN: begin
                to_d = (vpu_valid_out_1 || vpu_valid_out_2) ? '0 : to_q + TO_W'(1);
                if (out1_q == n_q && out2_q == n_q) begin
                    state_d = DONE;
                end else if (to_d == TO_W'(TIMEOUT_CYC)) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                    ec_d    = 2'b11;
                end
            end
            default: state_d = IDLE;
        endcase
        // abort silently drops the job, including any error raised this cycle
        if (abort && state_q != IDLE) begin
            state_d = IDLE;
            err_d   = 1'b0;
            ec_d    = ec_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pw_q    <= '0;
            dp_q    <= '0;
            n_q     <= '0;
            in1_q   <= '0;
            in2_q   <= '0;
            out1_q  <= '0;
            out2_q  <= '0;
            to_q    <= '0;
            ec_q    <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pw_q    <= pw_d;
            dp_q    <= (state_d == IDLE) ? 3'b000 : pw_d;
            n_q     <= n_d;
            in1_q   <= in1_d;
            in2_q   <= in2_d;
            out1_q  <= out1_d;
            out2_q  <= out2_d;
            to_q    <= to_d;
            ec_q    <= ec_d;
            err_q   <= err_d;
            busy_q  <= (state_d == RUN) || (state_d == DRAIN);
            done_q  <= (state_d == DONE);
        end
    end

    assign cmd_ready    = (state_q == IDLE);
    assign data_pathway = dp_q;
    assign row_idx_1    = in1_q;
    assign row_idx_2    = in2_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign err          = err_q;
    assign err_code     = ec_q;
endmodule

// File: tb/tb_vpu_pathway_sequencer.sv
// tb_vpu_pathway_sequencer: scoreboard bench; expected done/err events are
// queued as stimulus is driven and matched as the sequencer pulses them.
module tb_vpu_pathway_sequencer;
    logic        clk = 1'b0, rst = 1'b1;
    logic        cmd_valid = 1'b0, abort = 1'b0;
    logic [2:0]  cmd_pathway = '0;
    logic [15:0] cmd_num_rows = '0;
    logic        vi1 = 1'b0, vi2 = 1'b0, vo1 = 1'b0, vo2 = 1'b0;
    logic        cmd_ready, busy, done, err;
    logic [2:0]  data_pathway;
    logic [15:0] row_idx_1, row_idx_2;
    logic [1:0]  err_code;
    int          total = 0, bad = 0;
    logic [3:0]  exp_q[$];

    vpu_pathway_sequencer dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_pathway(cmd_pathway), .cmd_num_rows(cmd_num_rows), .abort(abort),
        .vpu_valid_in_1(vi1), .vpu_valid_in_2(vi2),
        .vpu_valid_out_1(vo1), .vpu_valid_out_2(vo2),
        .data_pathway(data_pathway), .row_idx_1(row_idx_1), .row_idx_2(row_idx_2),
        .busy(busy), .done(done), .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] pw, input logic [15:0] n);
        cmd_valid = 1'b1; cmd_pathway = pw; cmd_num_rows = n;
        tick();
        cmd_valid = 1'b0;
    endtask

    // event word: {done, err, err_code}
    always @(negedge clk)
        if (!rst && (done || err)) begin
            if (exp_q.size() == 0) chk("unexp_evt", {done, err, err_code}, 4'h0);
            else chk("evt", {done, err, err_code}, exp_q.pop_front());
        end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int r1, n;
        #2;
        chk("rst_ready", cmd_ready, 1);
        chk("rst_dp", data_pathway, 0);
        chk("rst_busy", {busy, done, err, err_code}, 0);
        chk("rst_rows", {row_idx_1, row_idx_2}, 0);
        @(posedge clk); #1 rst = 1'b0;

        // forward N=4, lane 2 one cycle behind, outputs start 3 cycles in
        send(3'b001, 16'd4);
        chk("fw_dp0", data_pathway, 3'b001);
        chk("fw_busy", busy, 1);
        chk("fw_ready", cmd_ready, 0);
        exp_q.push_back(4'b1000);
        r1 = 0;
        for (int i = 0; i < 8; i++) begin
            vi1 = (i < 4); vi2 = (i >= 1 && i < 5);
            vo1 = (i >= 3 && i < 7); vo2 = vo1;
            if (vi1 && r1 < 4) r1++;
            tick();
            chk("fw_dp", data_pathway, 3'b001);
            chk("fw_row1", row_idx_1, r1);
        end
        {vi1, vi2, vo1, vo2} = '0;
        chk("fw_done", done, 1);
        tick();
        chk("fw_done_clr", done, 0);
        chk("fw_dp_idle", data_pathway, 0);
        chk("fw_ready_idle", cmd_ready, 1);

        // bad commands
        exp_q.push_back(4'b0101);
        send(3'b000, 16'd5);
        chk("bad0_err", {err, err_code}, 3'b101);
        chk("bad0_ready", cmd_ready, 1);
        exp_q.push_back(4'b0101);
        send(3'b011, 16'd0);
        chk("bad1_err", {err, err_code}, 3'b101);
        tick();
        chk("bad_hold", {err, err_code, busy, cmd_ready}, 5'b00101);

        // overflow, transition N=2
        send(3'b010, 16'd2);
        chk("ov_code_clr", err_code, 0);
        for (int i = 0; i < 3; i++) begin
            vi1 = 1'b1; vi2 = (i < 2);
            if (i == 2) exp_q.push_back(4'b0110);
            tick();
        end
        {vi1, vi2} = '0;
        chk("ov_row1", row_idx_1, 2);
        chk("ov_err", {err, err_code}, 3'b110);
        vo1 = 1'b1; vo2 = 1'b1;
        tick(); tick();
        {vo1, vo2} = '0;
        exp_q.push_back(4'b1010);
        tick();
        chk("ov_done", done, 1);
        chk("ov_dp", data_pathway, 3'b010);
        tick();

        // timeout, backward N=3: lane 2 only gets two outputs
        send(3'b011, 16'd3);
        vi1 = 1'b1; vi2 = 1'b1;
        repeat (3) tick();
        {vi1, vi2} = '0;
        tick();
        vo2 = 1'b1;
        tick(); tick();
        vo2 = 1'b0;
        exp_q.push_back(4'b0111);
        n = 0;
        while (!err && n < 100) begin
            tick();
            n++;
        end
        chk("to_cycles", n, 64);
        chk("to_code", err_code, 2'b11);
        chk("to_idle", {busy, cmd_ready, data_pathway}, 5'b01000);

        // abort in DRAIN, then a fresh job
        send(3'b001, 16'd8);
        vi1 = 1'b1; vi2 = 1'b1;
        repeat (8) tick();
        {vi1, vi2} = '0;
        tick();
        vo1 = 1'b1;
        repeat (5) tick();
        vo1 = 1'b0;
        chk("ab_busy_pre", busy, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("ab_dp", data_pathway, 0);
        chk("ab_flags", {busy, done, err, cmd_ready}, 4'b0001);
        chk("ab_code", err_code, 0);
        send(3'b001, 16'd1);
        chk("ab_rows_clr", {row_idx_1, row_idx_2}, 0);
        chk("ab_new_dp", data_pathway, 3'b001);
        vi1 = 1'b1; vi2 = 1'b1;
        tick();
        {vi1, vi2} = '0;
        chk("ab_row", {row_idx_1, row_idx_2}, {16'd1, 16'd1});
        vo1 = 1'b1; vo2 = 1'b1;
        tick();
        {vo1, vo2} = '0;
        exp_q.push_back(4'b1000);
        tick();
        chk("ab_done", done, 1);
        tick();

        // async reset mid-RUN
        send(3'b011, 16'd3);
        vi1 = 1'b1;
        tick();
        vi1 = 1'b0;
        chk("ar_pre", {busy, row_idx_1}, {1'b1, 16'd1});
        #2 rst = 1'b1;
        #1;
        chk("ar_dp", data_pathway, 0);
        chk("ar_flags", {busy, cmd_ready, err_code}, 4'b0100);
        chk("ar_row", row_idx_1, 0);
        @(posedge clk); #1 rst = 1'b0;
        tick();

        chk("sb_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
